// File: rtl/weight_fetch_unit.sv
// Weight FIFO producer: streams MUL_SIZE-row weight tiles from weight memory into the weight FIFO.
// Optional feature: define WEIGHT_FETCH_PERF_EN to add the stall_cycles_o backpressure counter.
module weight_fetch_unit #(
    parameter int MUL_SIZE   = 16,
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_W     = 16,
    parameter int TILE_CNT_W = 8
) (
    input  logic                           clk_i,
    input  logic                           rst_i,
    input  logic                           instruction_i,
    input  logic [ADDR_W-1:0]              base_addr_i,
    input  logic [TILE_CNT_W-1:0]          num_tiles_i,
    output logic                           mem_rd_en_o,
    output logic [ADDR_W-1:0]              mem_addr_o,
    input  logic [MUL_SIZE*DATA_WIDTH-1:0] mem_rdata_i,
    input  logic                           fifo_full_i,
    output logic                           fifo_wr_en_o,
    output logic [MUL_SIZE*DATA_WIDTH-1:0] fifo_wdata_o,
    output logic                           tile_pushed_o,
    output logic                           busy_o,
    output logic                           done_o
`ifdef WEIGHT_FETCH_PERF_EN
    ,
    output logic [31:0]                    stall_cycles_o
`endif
);

    localparam int ROW_W = MUL_SIZE * DATA_WIDTH;
    localparam int IDX_W = (MUL_SIZE > 1) ? $clog2(MUL_SIZE) : 1;
    localparam int CNT_W = TILE_CNT_W + IDX_W;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(MUL_SIZE - 1);

    typedef enum logic [1:0] {IDLE, FETCH, DRAIN} state_t;

    state_t             state;
    state_t             state_nxt;
    logic [ADDR_W-1:0]  rd_addr;
    logic [CNT_W-1:0]   total_rows;
    logic [CNT_W-1:0]   issued;
    logic [CNT_W-1:0]   written;
    logic [IDX_W-1:0]   row_in_tile;
    logic               rd_pending;
    logic               skid_valid;
    logic [ROW_W-1:0]   skid_data;
    logic               start;
    logic               issue;
    logic               skid_wr;
    logic               direct_wr;
    logic               wr_en;
    logic               last_write;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Reads stall while the skid holds a row, so a returning row and a skid write never collide.
    always_comb begin
        start      = (state == IDLE) && instruction_i;
        issue      = (state == FETCH) && (issued < total_rows) && !fifo_full_i && !skid_valid;
        skid_wr    = skid_valid && !fifo_full_i;
        direct_wr  = rd_pending && !fifo_full_i;
        wr_en      = skid_wr || direct_wr;
        last_write = wr_en && ((written + CNT_W'(1)) == total_rows);

        mem_rd_en_o   = issue;
        mem_addr_o    = issue ? rd_addr : '0;
        fifo_wr_en_o  = wr_en;
        fifo_wdata_o  = skid_wr ? skid_data : (direct_wr ? mem_rdata_i : '0);
        tile_pushed_o = wr_en && (row_in_tile == LAST_IDX);

        state_nxt = state;
        case (state)
            IDLE:    if (instruction_i && (num_tiles_i != '0)) state_nxt = FETCH;
            FETCH:   if (issue && ((issued + CNT_W'(1)) == total_rows)) state_nxt = DRAIN;
            DRAIN:   if (last_write) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            rd_addr     <= '0;
            total_rows  <= '0;
            issued      <= '0;
            written     <= '0;
            row_in_tile <= '0;
            rd_pending  <= 1'b0;
            skid_valid  <= 1'b0;
            skid_data   <= '0;
            busy_o      <= 1'b0;
            done_o      <= 1'b0;
        end else begin
            done_o <= 1'b0;
            if (start) begin
                rd_addr     <= base_addr_i;
                total_rows  <= CNT_W'(num_tiles_i) * CNT_W'(MUL_SIZE);
                issued      <= '0;
                written     <= '0;
                row_in_tile <= '0;
                rd_pending  <= 1'b0;
                skid_valid  <= 1'b0;
                busy_o      <= (num_tiles_i != '0);
                done_o      <= (num_tiles_i == '0);
            end else begin
                rd_pending <= issue;
                if (issue) begin
                    rd_addr <= rd_addr + ADDR_W'(1);
                    issued  <= issued + CNT_W'(1);
                end
                if (rd_pending && fifo_full_i) begin
                    skid_valid <= 1'b1;
                    skid_data  <= mem_rdata_i;
                end else if (skid_wr) begin
                    skid_valid <= 1'b0;
                end
                if (wr_en) begin
                    written     <= written + CNT_W'(1);
                    row_in_tile <= (row_in_tile == LAST_IDX) ? '0 : row_in_tile + IDX_W'(1);
                end
                if ((state == DRAIN) && last_write) begin
                    busy_o <= 1'b0;
                    done_o <= 1'b1;
                end
            end
        end
    end

`ifdef WEIGHT_FETCH_PERF_EN
    logic [31:0] stall_cnt;
    logic        stall_now;

    // A stall is a full FIFO while rows remain to be read, a read is in flight, or the skid holds data.
    always_comb begin
        stall_now = ((state == FETCH) || (state == DRAIN)) && fifo_full_i &&
                    ((issued != total_rows) || rd_pending || skid_valid);
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            stall_cnt <= '0;
        end else if (start) begin
            stall_cnt <= '0;
        end else if (stall_now && (stall_cnt != '1)) begin
            stall_cnt <= stall_cnt + 32'd1;
        end
    end

    assign stall_cycles_o = stall_cnt;
`endif

endmodule

// File: tb/tb_weight_fetch_unit.sv
// Directed self-checking bench for weight_fetch_unit (MUL_SIZE=4) with a one-cycle-latency memory model.
module tb_weight_fetch_unit;

    localparam int MS = 4;
    localparam int DW = 8;
    localparam int AW = 16;
    localparam int TW = 8;
    localparam int RW = MS * DW;

    logic          clk_i = 1'b0;
    logic          rst_i = 1'b1;
    logic          instruction_i = 1'b0;
    logic [AW-1:0] base_addr_i = '0;
    logic [TW-1:0] num_tiles_i = '0;
    logic          mem_rd_en_o;
    logic [AW-1:0] mem_addr_o;
    logic [RW-1:0] mem_rdata_i = '0;
    logic          fifo_full_i = 1'b0;
    logic          fifo_wr_en_o;
    logic [RW-1:0] fifo_wdata_o;
    logic          tile_pushed_o;
    logic          busy_o;
    logic          done_o;
`ifdef WEIGHT_FETCH_PERF_EN
    logic [31:0]   stall_cycles_o;
`endif

    weight_fetch_unit #(
        .MUL_SIZE(MS), .DATA_WIDTH(DW), .ADDR_W(AW), .TILE_CNT_W(TW)
    ) dut (
        .clk_i(clk_i),
        .rst_i(rst_i),
        .instruction_i(instruction_i),
        .base_addr_i(base_addr_i),
        .num_tiles_i(num_tiles_i),
        .mem_rd_en_o(mem_rd_en_o),
        .mem_addr_o(mem_addr_o),
        .mem_rdata_i(mem_rdata_i),
        .fifo_full_i(fifo_full_i),
        .fifo_wr_en_o(fifo_wr_en_o),
        .fifo_wdata_o(fifo_wdata_o),
        .tile_pushed_o(tile_pushed_o),
        .busy_o(busy_o),
        .done_o(done_o)
`ifdef WEIGHT_FETCH_PERF_EN
        ,
        .stall_cycles_o(stall_cycles_o)
`endif
    );

    always #5 clk_i = ~clk_i;

    int cyc = 0;
    int start_cyc = 0;
    int total = 0;
    int bad = 0;

    logic [AW-1:0] rd_addr_q[$];
    int            rd_cyc_q[$];
    logic [RW-1:0] wr_q[$];
    int            wr_cyc_q[$];
    int            tp_q[$];
    int            done_cnt = 0;
    int            done_cyc = -1;
    int            busy_cnt = 0;
    int            full_wr_viol = 0;

    function automatic logic [RW-1:0] row_of(input logic [AW-1:0] a);
        return {~a, a};
    endfunction

    always @(posedge clk_i) cyc <= cyc + 1;

    // Weight memory: data for an accepted read appears exactly one cycle later, garbage otherwise.
    always @(posedge clk_i) mem_rdata_i <= mem_rd_en_o ? row_of(mem_addr_o) : 32'hDEAD_BEEF;

    always @(negedge clk_i) begin
        if (mem_rd_en_o) begin
            rd_addr_q.push_back(mem_addr_o);
            rd_cyc_q.push_back(cyc);
        end
        if (fifo_wr_en_o) begin
            if (tile_pushed_o) tp_q.push_back(wr_q.size());
            if (fifo_full_i) full_wr_viol++;
            wr_q.push_back(fifo_wdata_o);
            wr_cyc_q.push_back(cyc);
        end
        if (done_o) begin
            done_cnt++;
            done_cyc = cyc;
        end
        if (busy_o) busy_cnt++;
    end

    task automatic check_output(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic clear_log();
        rd_addr_q.delete();
        rd_cyc_q.delete();
        wr_q.delete();
        wr_cyc_q.delete();
        tp_q.delete();
        done_cnt = 0;
        done_cyc = -1;
        busy_cnt = 0;
        full_wr_viol = 0;
    endtask

    task automatic apply_stimulus(input logic [AW-1:0] base, input logic [TW-1:0] num);
        @(posedge clk_i); #1;
        instruction_i = 1'b1;
        base_addr_i   = base;
        num_tiles_i   = num;
        start_cyc     = cyc;
        @(posedge clk_i); #1;
        instruction_i = 1'b0;
    endtask

    task automatic wait_done(input int limit);
        int n = 0;
        while (done_cnt == 0 && n < limit) begin
            @(negedge clk_i);
            n++;
        end
        check_output("done_within_budget", 64'(done_cnt != 0), 64'd1);
        repeat (3) @(negedge clk_i);
    endtask

    task automatic check_stream(input string tag, input logic [AW-1:0] base, input int rows);
        check_output({tag, "_rd_count"}, 64'(rd_addr_q.size()), 64'(rows));
        check_output({tag, "_wr_count"}, 64'(wr_q.size()), 64'(rows));
        for (int i = 0; i < rows; i++) begin
            check_output($sformatf("%s_rd_addr%0d", tag, i), 64'(rd_addr_q[i]), 64'(AW'(base + AW'(i))));
            check_output($sformatf("%s_wr_data%0d", tag, i), 64'(wr_q[i]), 64'(row_of(AW'(base + AW'(i)))));
        end
        check_output({tag, "_wr_while_full"}, 64'(full_wr_viol), 64'd0);
    endtask

    initial begin
        #100000;
        $display("[TB] FAIL watchdog expired observed=timeout expected=finish");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        repeat (2) @(negedge clk_i);
        check_output("rst_mem_rd_en", 64'(mem_rd_en_o), 64'd0);
        check_output("rst_mem_addr", 64'(mem_addr_o), 64'd0);
        check_output("rst_fifo_wr_en", 64'(fifo_wr_en_o), 64'd0);
        check_output("rst_fifo_wdata", 64'(fifo_wdata_o), 64'd0);
        check_output("rst_tile_pushed", 64'(tile_pushed_o), 64'd0);
        check_output("rst_busy", 64'(busy_o), 64'd0);
        check_output("rst_done", 64'(done_o), 64'd0);
        rst_i = 1'b0;

        $display("[TB] two tiles from 0x0010, no backpressure");
        clear_log();
        apply_stimulus(16'h0010, 8'd2);
        wait_done(100);
        check_stream("t1", 16'h0010, 8);
        for (int i = 0; i < 8; i++)
            check_output($sformatf("t1_rd_cycle%0d", i), 64'(rd_cyc_q[i] - start_cyc), 64'(1 + i));
        check_output("t1_first_wr_cycle", 64'(wr_cyc_q[0] - start_cyc), 64'd2);
        check_output("t1_tile_push_count", 64'(tp_q.size()), 64'd2);
        check_output("t1_tile_push_a", 64'(tp_q[0]), 64'd3);
        check_output("t1_tile_push_b", 64'(tp_q[1]), 64'd7);
        check_output("t1_done_cycle", 64'(done_cyc - start_cyc), 64'd10);
        check_output("t1_done_pulses", 64'(done_cnt), 64'd1);
        check_output("t1_busy_cycles", 64'(busy_cnt), 64'd9);

        $display("[TB] zero tiles");
        clear_log();
        apply_stimulus(16'h0100, 8'd0);
        repeat (4) @(negedge clk_i);
        check_output("t2_done_cycle", 64'(done_cyc - start_cyc), 64'd1);
        check_output("t2_done_pulses", 64'(done_cnt), 64'd1);
        check_output("t2_rd_count", 64'(rd_addr_q.size()), 64'd0);
        check_output("t2_wr_count", 64'(wr_q.size()), 64'd0);
        check_output("t2_busy_cycles", 64'(busy_cnt), 64'd0);

        $display("[TB] backpressure on the return cycle of row 2");
        clear_log();
        apply_stimulus(16'h0000, 8'd2);
        repeat (3) @(posedge clk_i);
        #1 fifo_full_i = 1'b1;
        #2 check_output("t3_no_wr_while_full", 64'(fifo_wr_en_o), 64'd0);
        check_output("t3_no_rd_while_full", 64'(mem_rd_en_o), 64'd0);
        repeat (3) @(posedge clk_i);
        #1 fifo_full_i = 1'b0;
        wait_done(100);
        check_stream("t3", 16'h0000, 8);
        check_output("t3_row2_wr_cycle", 64'(wr_cyc_q[2] - start_cyc), 64'd7);
        check_output("t3_row3_rd_cycle", 64'(rd_cyc_q[3] - start_cyc), 64'd8);
        check_output("t3_done_cycle", 64'(done_cyc - start_cyc), 64'd14);
`ifdef WEIGHT_FETCH_PERF_EN
        check_output("t3_stall_cycles", 64'(stall_cycles_o), 64'd3);

        $display("[TB] five blocked cycles");
        clear_log();
        apply_stimulus(16'h0080, 8'd1);
        @(posedge clk_i);
        #1 fifo_full_i = 1'b1;
        repeat (5) @(posedge clk_i);
        #1 fifo_full_i = 1'b0;
        wait_done(100);
        check_stream("perf", 16'h0080, 4);
        check_output("perf_done_cycle", 64'(done_cyc - start_cyc), 64'd12);
        check_output("perf_stall_cycles", 64'(stall_cycles_o), 64'd5);
`endif

        $display("[TB] address wrap from 0xFFFE");
        clear_log();
        apply_stimulus(16'hFFFE, 8'd1);
`ifdef WEIGHT_FETCH_PERF_EN
        check_output("t4_stall_cleared", 64'(stall_cycles_o), 64'd0);
`endif
        wait_done(100);
        check_stream("t4", 16'hFFFE, 4);
        check_output("t4_done_cycle", 64'(done_cyc - start_cyc), 64'd6);

        $display("[TB] reset after three writes");
        clear_log();
        apply_stimulus(16'h0020, 8'd2);
        for (int n = 0; n < 50 && wr_q.size() < 3; n++) @(negedge clk_i);
        check_output("t5_three_writes", 64'(wr_q.size()), 64'd3);
        @(posedge clk_i); #1;
        check_output("t5_pre_rd_en", 64'(mem_rd_en_o), 64'd1);
        check_output("t5_pre_wr_en", 64'(fifo_wr_en_o), 64'd1);
        rst_i = 1'b1;
        #1;
        check_output("t5_rst_rd_en", 64'(mem_rd_en_o), 64'd0);
        check_output("t5_rst_addr", 64'(mem_addr_o), 64'd0);
        check_output("t5_rst_wr_en", 64'(fifo_wr_en_o), 64'd0);
        check_output("t5_rst_wdata", 64'(fifo_wdata_o), 64'd0);
        check_output("t5_rst_busy", 64'(busy_o), 64'd0);
        @(negedge clk_i);
        rst_i = 1'b0;
        clear_log();
        repeat (4) @(negedge clk_i);
        check_output("t5_idle_no_rd", 64'(rd_addr_q.size()), 64'd0);
        check_output("t5_idle_no_wr", 64'(wr_q.size()), 64'd0);
        clear_log();
        apply_stimulus(16'h0040, 8'd1);
        wait_done(100);
        check_stream("t5", 16'h0040, 4);
        check_output("t5_done_cycle", 64'(done_cyc - start_cyc), 64'd6);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/weight_fetch_unit.md
# weight_fetch_unit

Producer side of the weight FIFO. On an instruction it streams weight tiles, one MUL_SIZE-wide row per cycle, from on-chip weight memory into the weight FIFO. It honours the FIFO full flag and a fixed one-cycle memory read latency, so the downstream weight loader sees a gap-free stream of valid rows whenever the FIFO has space. Sits between the weight memory and the weight FIFO, alongside the instruction decoder.

## Interface
- MUL_SIZE, 16, systolic array dimension; rows per weight tile
- DATA_WIDTH, 8, bits per weight element
- ADDR_W, 16, weight memory row-address width
- TILE_CNT_W, 8, width of tile count
- clk_i  in  1  clock; all logic on posedge
- rst_i  in  1  reset, asynchronous, active-high
- instruction_i  in  1  start pulse; accepted only in IDLE
- base_addr_i  in  ADDR_W  first row address; sampled with instruction_i
- num_tiles_i  in  TILE_CNT_W  tile count; sampled with instruction_i
- mem_rd_en_o  out  1  weight memory read strobe
- mem_addr_o  out  ADDR_W  row address for mem_rd_en_o
- mem_rdata_i  in  MUL_SIZE*DATA_WIDTH  row data, valid exactly 1 cycle after mem_rd_en_o
- fifo_full_i  in  1  weight FIFO cannot accept a write this cycle
- fifo_wr_en_o  out  1  FIFO write strobe
- fifo_wdata_o  out  MUL_SIZE*DATA_WIDTH  FIFO write data
- tile_pushed_o  out  1  pulse: last row of a tile written this cycle
- busy_o  out  1  high from start acceptance to done
- done_o  out  1  one-cycle pulse after final write

## Operation
- States: IDLE, FETCH, DRAIN.
- IDLE, instruction_i=1: latch base_addr_i into the read-address register. Latch total_rows = num_tiles_i*MUL_SIZE (width TILE_CNT_W+log2(MUL_SIZE)). Clear the issue and write counters. Go to FETCH. If num_tiles_i==0, stay in IDLE and pulse done_o next cycle; no reads are issued.
- FETCH issue condition: issued<total_rows & !fifo_full_i & skid empty. When it holds, mem_rd_en_o=1 and mem_addr_o = current address. Address and issue count increment on that edge. Address wraps modulo 2^ADDR_W.
- Return path: rd_pending flag set on each issue; data arrives in the next cycle.
  - Returning row with !fifo_full_i: written directly.
  - Returning row with fifo_full_i: captured in a one-entry skid register.
- Skid drain: skid full & !fifo_full_i -> write the skid row and clear the skid. Skid has priority over new reads. The issue condition blocks reads while the skid is full, so a return and a skid write never coincide.
- Counters:
  - Write counter increments on every fifo_wr_en_o.
  - Row-in-tile counter wraps at MUL_SIZE-1; tile_pushed_o is asserted on that write.
- FETCH -> DRAIN when issued reaches total_rows. DRAIN -> IDLE when writes reach total_rows; done_o pulses the following cycle.
- instruction_i outside IDLE: ignored.
- fifo_wr_en_o is never asserted while fifo_full_i=1.

## Timing
- Reset values: mem_rd_en_o=0, mem_addr_o=0, fifo_wr_en_o=0, fifo_wdata_o=0, tile_pushed_o=0, busy_o=0, done_o=0; state IDLE; skid and rd_pending empty.
- mem_rd_en_o, mem_addr_o, fifo_wr_en_o and fifo_wdata_o are combinational from state/counters/skid, fifo_full_i and mem_rdata_i. done_o and busy_o are registered.
- Start edge t -> first read in cycle t+1 -> first write in t+2 (FIFO not full).
- Steady state: 1 row/cycle. N tiles with no backpressure: last write at t+1+N*MUL_SIZE, done_o at t+2+N*MUL_SIZE.
- fifo_full_i asserted in the cycle data returns: no data loss. Resume latency after full deasserts: 0 cycles for the skid write; the next read issues one cycle later.
- Asynchronous reset mid-transfer: outputs drop immediately; outstanding read data is discarded; the block restarts only on a new instruction_i.

## Configuration
- WEIGHT_FETCH_PERF_EN defined: adds output stall_cycles_o (32 bit). It counts FETCH/DRAIN cycles in which fifo_full_i=1 and a read or write was pending. Cleared on start acceptance; saturates at all-ones; holds after done.
- WEIGHT_FETCH_PERF_EN not defined: port and counter absent; behaviour otherwise identical.

## Test plan
- MUL_SIZE=4, base 0x0010, 2 tiles, fifo_full_i=0 -> addresses 0x10..0x17 on consecutive cycles. 8 writes in order; tile_pushed_o on writes 4 and 8; done_o 10 cycles after start edge.
- num_tiles_i=0 -> no mem_rd_en_o, no writes, done_o one cycle after start, busy_o stays 0.
- fifo_full_i raised in the return cycle of row 2 for 3 cycles -> row 2 held in skid, no reads during full. Skid written in the first not-full cycle; all 8 rows in order, none duplicated.
- base 0xFFFE, 1 tile (MUL_SIZE=4) -> addresses 0xFFFE, 0xFFFF, 0x0000, 0x0001.
- rst_i pulsed after 3 writes -> outputs 0 asynchronously. A new instruction afterwards starts cleanly from the new base.
- WEIGHT_FETCH_PERF_EN, 5 blocked cycles -> stall_cycles_o=5 at done; it clears to 0 on the next start.
